// File: rtl/cfg_pkg.sv
// Shared types and constants for the configuration byte deserialiser.
// The frame is a sync byte, Dim*Dim ten-byte words, then an XOR checksum.
package cfg_pkg;

    localparam int WORD_W         = 77;
    localparam int BYTES_PER_WORD = 10;
    localparam int LANE_W         = 4;
    localparam int PAD_W          = 8 * BYTES_PER_WORD - WORD_W;
    localparam int TOP_DATA_W     = 8 - PAD_W;

    localparam logic [7:0]        SYNC_BYTE = 8'hA5;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(BYTES_PER_WORD - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HOLD,
        ST_CHECK,
        ST_DONE,
        ST_ERR
    } cfg_state_e;

    // The last byte of a word carries the pad bits in its upper PAD_W positions.
    function automatic logic pad_nonzero(input logic [7:0] top_byte);
        return |top_byte[7:TOP_DATA_W];
    endfunction

endpackage

// File: rtl/cfg_word_assembler.sv
// Byte-lane word register and running XOR checksum, sequenced by the
// deserialiser FSM through clear/load enables.
module cfg_word_assembler
    import cfg_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              clear_i,
    input  logic              load_i,
    input  logic [LANE_W-1:0] lane_i,
    input  logic [7:0]        byte_i,
    output logic [WORD_W-1:0] word_o,
    output logic [7:0]        csum_o,
    output logic              pad_err_o
);

    logic [WORD_W-1:0] word_q, word_d;
    logic [7:0]        csum_q, csum_d;

    // NOTE: every variable written here gets a default first, so no latch is inferred.
    always_comb begin
        word_d = word_q;
        csum_d = csum_q;
        if (clear_i) begin
            csum_d = '0;
        end else if (load_i) begin
            csum_d = csum_q ^ byte_i;
            if (lane_i == LAST_LANE) begin
                word_d[WORD_W-1 -: TOP_DATA_W] = byte_i[TOP_DATA_W-1:0];
            end else begin
                word_d[{lane_i, 3'b000} +: 8] = byte_i;
            end
        end
    end

    // NOTE: the word register is reset (not left as uninitialised storage) because word_o must read zero after reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            word_q <= '0;
            csum_q <= '0;
        end else begin
            word_q <= word_d;
            csum_q <= csum_d;
        end
    end

    assign word_o    = word_q;
    assign csum_o    = csum_q;
    assign pad_err_o = load_i && (lane_i == LAST_LANE) && pad_nonzero(byte_i);

endmodule

// File: rtl/cfg_byte_deser.sv
// Configuration stream deserialiser: hunts for the sync byte, assembles
// Dim*Dim words with a valid/ready hand-off, then verifies the checksum.
module cfg_byte_deser
    import cfg_pkg::*;
#(
    parameter int         Dim      = 4,
    parameter logic [7:0] SyncByte = SYNC_BYTE
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [7:0]        byte_i,
    input  logic              byte_v_i,
    output logic              byte_r_o,
    output logic [WORD_W-1:0] word_o,
    output logic              word_v_o,
    input  logic              word_r_i,
    output logic              done_o,
    output logic              err_o
);

    localparam int                WORDS         = Dim * Dim;
    localparam int                WCNT_W        = $clog2(WORDS + 1);
    localparam logic [WCNT_W-1:0] LAST_WORD_CNT = WCNT_W'(WORDS);

    cfg_state_e        state_q, state_d;
    logic [LANE_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [WCNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [WCNT_W-1:0] word_cnt_inc;
    logic              word_v_q, word_v_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              byte_fire;
    logic              asm_clear;
    logic              asm_load;
    logic [7:0]        csum;
    logic              pad_err;

    assign byte_r_o     = rst_ni && (state_q inside {ST_IDLE, ST_LOAD, ST_CHECK});
    assign byte_fire    = byte_v_i && byte_r_o;
    assign word_cnt_inc = word_cnt_q + 1'b1;

    cfg_word_assembler u_asm (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (asm_clear),
        .load_i    (asm_load),
        .lane_i    (byte_cnt_q),
        .byte_i    (byte_i),
        .word_o    (word_o),
        .csum_o    (csum),
        .pad_err_o (pad_err)
    );

    // NOTE: next-state logic uses blocking assignments; the registers below use only non-blocking ones.
    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        word_v_d   = word_v_q;
        done_d     = done_q;
        err_d      = err_q;
        asm_clear  = 1'b0;
        asm_load   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (byte_fire && (byte_i == SyncByte)) begin
                    state_d    = ST_LOAD;
                    byte_cnt_d = '0;
                    word_cnt_d = '0;
                    asm_clear  = 1'b1;
                end
            end
            ST_LOAD: begin
                if (byte_fire) begin
                    asm_load = 1'b1;
                    if (byte_cnt_q == LAST_LANE) begin
                        state_d  = ST_HOLD;
                        word_v_d = 1'b1;
                        if (pad_err) begin
                            err_d = 1'b1;
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (word_r_i) begin
                    word_v_d   = 1'b0;
                    word_cnt_d = word_cnt_inc;
                    if (word_cnt_inc == LAST_WORD_CNT) begin
                        state_d = ST_CHECK;
                    end else begin
                        state_d    = ST_LOAD;
                        byte_cnt_d = '0;
                    end
                end
            end
            ST_CHECK: begin
                // A pad error anywhere in the frame poisons it even if the checksum matches.
                if (byte_fire) begin
                    if ((byte_i == csum) && !err_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            ST_DONE, ST_ERR: begin
                state_d = state_q;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            word_v_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
            word_v_q   <= word_v_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign word_v_o = word_v_q;
    assign done_o   = done_q;
    assign err_o    = err_q;

endmodule

// File: tb/tb_cfg_byte_deser.sv
// Scoreboard bench for cfg_byte_deser: a driver pushes expected words as it
// sends each frame, a monitor pops and compares on every word hand-off.
module tb_cfg_byte_deser;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [7:0]  byte_i;
    logic        byte_v_i;
    logic        byte_r_o;
    logic [76:0] word_o;
    logic        word_v_o;
    logic        word_r_i;
    logic        done_o;
    logic        err_o;

    always #5 clk_i = ~clk_i;

    cfg_byte_deser dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .byte_i   (byte_i),
        .byte_v_i (byte_v_i),
        .byte_r_o (byte_r_o),
        .word_o   (word_o),
        .word_v_o (word_v_o),
        .word_r_i (word_r_i),
        .done_o   (done_o),
        .err_o    (err_o)
    );

    typedef struct packed {
        logic [76:0] word;
        logic        err;
    } exp_t;

    localparam logic [76:0] WORD0 = 77'h1F_0807060504030201_00;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          total     = 0;
    int          bad       = 0;
    int          popped    = 0;
    int          stall_at  = -1;
    int          stall_cnt = 0;
    bit          stuck     = 1'b0;
    logic [76:0] held;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: a word transfers at the next rising edge when valid and ready are both high here.
    always @(negedge clk_i) begin
        if (rst_ni && word_v_o && word_r_i) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_word: got %h expected no word", word_o);
            end else begin
                mon_e = exp_q.pop_front();
                check($sformatf("word%0d", popped), 80'(word_o), 80'(mon_e.word));
                check($sformatf("word%0d_err", popped), 80'(err_o), 80'(mon_e.err));
                popped++;
            end
        end
    end

    // Downstream sink: ready high, except a 20-cycle stall on the selected word.
    initial begin
        word_r_i = 1'b1;
        forever begin
            @(posedge clk_i);
            #1;
            if (stall_at >= 0 && popped == stall_at && word_v_o && stall_cnt < 20) begin
                if (stall_cnt == 0) held = word_o;
                else check("stall_word_stable", 80'(word_o), 80'(held));
                check("stall_byte_r", 80'(byte_r_o), 80'(0));
                word_r_i = 1'b0;
                stall_cnt++;
            end else begin
                word_r_i = 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the byte has transferred.
    task automatic send_byte(input logic [7:0] b);
        int waited = 0;
        if (stuck) return;
        byte_i   = b;
        byte_v_i = 1'b1;
        @(negedge clk_i);
        while (!byte_r_o) begin
            waited++;
            if (waited > 100) begin
                stuck = 1'b1;
                total++;
                bad++;
                $display("FAIL byte_accept_timeout: byte_r_o got 0 expected 1");
                byte_v_i = 1'b0;
                return;
            end
            @(negedge clk_i);
        end
        step();
        byte_v_i = 1'b0;
    endtask

    task automatic send_frame(input bit garbage, input bit bad_csum, input int pad_word,
                              input int n_words, input bit with_csum);
        logic [7:0]  csum = 8'h00;
        logic [7:0]  b[10];
        logic [76:0] w_exp;
        if (garbage) begin
            send_byte(8'h00);
            send_byte(8'hFF);
        end
        send_byte(8'hA5);
        for (int w = 0; w < n_words; w++) begin
            for (int j = 0; j < 9; j++) b[j] = 8'(w + j);
            b[9]  = (w == pad_word) ? 8'hE0 : 8'h1F;
            w_exp = {b[9][4:0], b[8], b[7], b[6], b[5], b[4], b[3], b[2], b[1], b[0]};
            if (w == 0 && pad_word != 0) w_exp = WORD0;
            exp_q.push_back('{word: w_exp, err: (pad_word >= 0 && w >= pad_word)});
            for (int j = 0; j < 10; j++) begin
                csum = csum ^ b[j];
                send_byte(b[j]);
            end
        end
        if (with_csum) send_byte(bad_csum ? (csum ^ 8'h01) : csum);
    endtask

    task automatic do_reset();
        step();
        rst_ni   = 1'b0;
        byte_v_i = 1'b0;
        @(negedge clk_i);
        check("rst_byte_r_low", 80'(byte_r_o), 80'(0));
        step();
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("rst_word_v", 80'(word_v_o), 80'(0));
        check("rst_done", 80'(done_o), 80'(0));
        check("rst_err", 80'(err_o), 80'(0));
        check("rst_word", 80'(word_o), 80'(0));
        check("rst_idle_byte_r", 80'(byte_r_o), 80'(1));
        exp_q.delete();
        popped    = 0;
        stall_at  = -1;
        stall_cnt = 0;
        stuck     = 1'b0;
        step();
    endtask

    task automatic end_checks(input string tag, input bit exp_done, input bit exp_err);
        int n = 0;
        @(negedge clk_i);
        while (!(done_o || err_o) && n < 20) begin
            n++;
            @(negedge clk_i);
        end
        check({tag, "_done"}, 80'(done_o), 80'(exp_done));
        check({tag, "_err"}, 80'(err_o), 80'(exp_err));
        check({tag, "_byte_r"}, 80'(byte_r_o), 80'(0));
        check({tag, "_word_v"}, 80'(word_v_o), 80'(0));
        check({tag, "_words_left"}, 80'(exp_q.size()), 80'(0));
        check({tag, "_words_seen"}, 80'(popped), 80'(16));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        rst_ni   = 1'b0;
        byte_v_i = 1'b0;
        byte_i   = 8'h00;

        do_reset();
        send_frame(1'b0, 1'b0, -1, 16, 1'b1);
        end_checks("good", 1'b1, 1'b0);

        do_reset();
        send_frame(1'b1, 1'b0, -1, 16, 1'b1);
        end_checks("garbage", 1'b1, 1'b0);

        do_reset();
        send_frame(1'b0, 1'b1, -1, 16, 1'b1);
        end_checks("bad_csum", 1'b0, 1'b1);

        do_reset();
        send_frame(1'b0, 1'b0, 3, 16, 1'b1);
        end_checks("pad", 1'b0, 1'b1);

        do_reset();
        stall_at = 5;
        send_frame(1'b0, 1'b0, -1, 16, 1'b1);
        end_checks("stall", 1'b1, 1'b0);
        check("stall_cycles", 80'(stall_cnt), 80'(20));

        do_reset();
        send_frame(1'b0, 1'b0, -1, 8, 1'b0);
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            n++;
            @(negedge clk_i);
        end
        check("midreset_drain", 80'(exp_q.size()), 80'(0));
        check("midreset_not_done", 80'(done_o), 80'(0));
        do_reset();
        send_frame(1'b0, 1'b0, -1, 16, 1'b1);
        end_checks("after_reset", 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cfg_byte_deser.md
CFG_BYTE_DESER -- requirements
Module: cfg_byte_deser

Interface
REQ-001 Parameter Dim, default 4, fabric tile dimension; frame carries Dim*Dim words.
REQ-002 Parameter SyncByte, default 8'hA5, frame start marker.
REQ-003 clk_i  input  1  single clock; all logic on rising edge.
REQ-004 rst_ni  input  1  reset, synchronous, active-low.
REQ-005 byte_i  input  8  configuration stream byte.
REQ-006 byte_v_i  input  1  byte_i valid.
REQ-007 byte_r_o  output  1  block accepts byte_i this cycle; a byte transfers when byte_v_i & byte_r_o.
REQ-008 word_o  output  77  assembled configuration word for the downstream column loader.
REQ-009 word_v_o  output  1  word_o valid.
REQ-010 word_r_i  input  1  downstream ready; a word transfers when word_v_o & word_r_i.
REQ-011 done_o  output  1  frame received, checksum good; sticky.
REQ-012 err_o  output  1  frame error; sticky.

Function
REQ-013 Frame format: SyncByte, then Dim*Dim words of 10 bytes each, least-significant byte first, then one checksum byte.
REQ-014 Checksum byte SHALL equal the XOR of all 10*Dim*Dim word bytes; SyncByte is excluded.
REQ-015 Each word occupies bits 79:0 of its 10 bytes; word_o = bits 76:0; bits 79:77 are pad and SHALL be zero.
REQ-016 States: IDLE, LOAD, HOLD, CHECK, DONE, ERR.
REQ-017 IDLE: byte_r_o=1; accepted byte equal to SyncByte -> LOAD with byte count 0, word count 0, checksum 0; any other accepted byte is discarded and the state stays IDLE.
REQ-018 LOAD: byte_r_o=1; each accepted byte goes into byte lane (byte count) and is XORed into the checksum.
REQ-019 LOAD: the 10th accepted byte -> HOLD; word_v_o SHALL rise the cycle after that byte transfers.
REQ-020 HOLD: byte_r_o=0; word_o and word_v_o stay stable until word_r_i=1.
REQ-021 HOLD and word_r_i=1: word count increments; if the new count equals Dim*Dim -> CHECK, otherwise -> LOAD with byte count 0.
REQ-022 Nonzero pad bits in any word: err_o is set when that word enters HOLD, and the word is still presented.
REQ-023 CHECK: byte_r_o=1; the accepted byte equal to the running checksum with no pad error -> DONE; otherwise -> ERR.
REQ-024 DONE: done_o=1; ERR: err_o=1; in both states byte_r_o=0 and word_v_o=0; the block leaves them only on reset.
REQ-025 Counters: byte count is 4 bits (0..9); word count is $clog2(Dim*Dim+1) bits; neither wraps within a frame.
REQ-026 byte_v_i=0 in LOAD/CHECK: the state is held indefinitely; there is no timeout.
REQ-027 word_r_i while word_v_o=0 is ignored.
REQ-028 Throughput: one byte per cycle in LOAD; minimum 11 cycles per word with word_r_i held high.

Reset
REQ-029 rst_ni=0 at a clock edge -> IDLE, byte/word counts 0, checksum 0, word_v_o=0, done_o=0, err_o=0, word_o=0; byte_r_o=0 while rst_ni=0.
REQ-030 Reset mid-frame aborts the frame; the next frame SHALL begin with SyncByte.

Structure
REQ-031 Package cfg_pkg holds WORD_W=77, BYTES_PER_WORD=10, SYNC_BYTE default, and the state enum typedef.
REQ-032 One sub-module cfg_word_assembler: byte-lane register plus XOR accumulator, with load/clear enables driven by the FSM.
REQ-033 word_o and word_v_o SHALL be driven directly from registers, with no combinational path from byte_i.

Verification
REQ-034 Good frame, Dim=4: A5; 16 words of bytes k..k+9 with byte 9 = 8'h1F; correct XOR; word_r_i=1 -> 16 word_v_o pulses, word 0 = 77'h1F_0807060504030201_00, then done_o=1, err_o=0.
REQ-035 Garbage 8'h00, 8'hFF before A5 -> both discarded; frame decodes identically to REQ-034.
REQ-036 Wrong checksum (expected XOR ^ 8'h01) -> all 16 words delivered, then err_o=1, done_o=0, byte_r_o=0.
REQ-037 Word 3 byte 9 = 8'hE0 -> err_o=1 at that word's HOLD; state ERR after CHECK regardless of the checksum value.
REQ-038 word_r_i=0 for 20 cycles on word 5 -> word_o stable, byte_r_o=0 throughout, no bytes lost after release.
REQ-039 rst_ni=0 for 1 cycle after word 7 -> next cycle IDLE, all outputs 0; a fresh frame then completes with done_o=1.
